write_buffer: RTL and testbench
===============================

Name: write_buffer

Overview:
- Posted-write buffer between the cache's memory-side port (maddr/mout/min/mre/mwe/mready) and main memory.
- Absorbs cache writebacks with zero wait while space remains, and coalesces repeated writes to the same address.
- Forwards buffered data to cache reads; drains entries to memory in FIFO order.
- Presents the same pulse/ready handshake upstream that it consumes downstream.

Parameters:
- ADDR_WIDTH, 64, address width in bits.
- WORD_WIDTH, 64, data word width in bits.
- DEPTH_BITS, 2, buffer holds 2^DEPTH_BITS entries (default 4).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- addr  in  ADDR_WIDTH  request address from cache (cache maddr).
- din  in  WORD_WIDTH  write data from cache (cache mout).
- dout  out  WORD_WIDTH  read data to cache (cache min), registered.
- re  in  1  read pulse, one cycle, sampled only when ready=1.
- we  in  1  write pulse, one cycle, sampled only when ready=1.
- ready  out  1  idle/accepting (cache mready).
- maddr  out  ADDR_WIDTH  memory address, registered.
- mout  out  WORD_WIDTH  memory write data, registered.
- min  in  WORD_WIDTH  memory read data.
- mre  out  1  memory read pulse, registered.
- mwe  out  1  memory write pulse, registered.
- mready  in  1  memory idle.
- empty  out  1  no valid entries and no drain in flight.

Behaviour:
- Reset (rst=0, async):
  - Clears all entry valid bits, FIFO pointers, count, in-flight flags and state (S_IDLE).
  - Outputs: mre=0, mwe=0, maddr=0, mout=0, dout=0, ready=0, empty=1.
  - ready rises the first cycle after rst=1.
  - A memory op in flight when reset asserts is abandoned.
- Handshake (both sides):
  - A pulse is legal only while ready/mready=1.
  - The op completes on the first later cycle where ready/mready=1 and the pulse is low.
  - Memory must drop mready no later than the cycle after a pulse; min is valid on the completion cycle.
- Upstream priority: re wins over we if both are asserted; we is ignored in that case.
- ready = (state==S_IDLE) && (count < DEPTH).
- Write accepted (we & ready):
  - Coalesce: if a valid entry matches addr and is not the head currently being drained, overwrite its data. Count is unchanged.
  - Otherwise push {addr,din} at tail; count+1.
  - Zero wait: ready stays 1 unless the buffer is now full.
- Read accepted (re & ready):
  - Compare addr against all valid entries, including a head in flight.
  - Hit: dout <= data of the newest matching entry at the accept edge; state stays S_IDLE, so the read completes next cycle.
  - Miss: latch addr; state -> S_RD_ISSUE.
- S_RD_ISSUE (ready=0):
  - When no drain is in flight and mready=1: mre<=1 for one cycle, maddr<=latched addr; -> S_RD_WAIT.
  - A read miss takes priority over starting a new drain.
- S_RD_WAIT (ready=0): on mready=1 && mre=0: dout <= min; -> S_IDLE.
- Drain engine (independent flag drain_busy):
  - Starts when count>0, !drain_busy, mready=1, state not S_RD_ISSUE/S_RD_WAIT.
  - On start: mwe<=1 for one cycle, maddr/mout <= head; drain_busy=1.
  - Completion (mready=1 && mwe=0): pop head; count-1; drain_busy=0.
  - A new drain may start the following cycle.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; pointers both advance.
  - Coalesce target is head and head in flight: new entry is pushed instead (the in-flight data is not modified).
  - Full buffer: ready=0 until a pop.
- Pointer wrap: pointers are DEPTH_BITS wide and wrap naturally. count is DEPTH_BITS+1 bits, range 0..DEPTH.
- Newest-match rule: search order runs from tail-1 back toward head.
- empty = (count==0) && !drain_busy.

Decomposition:
- Shared include (memsim_defs): state encodings S_IDLE=0, S_RD_ISSUE=1, S_RD_WAIT=2; STATE_BITS=2.
- One sub-module, wb_match:
  - Combinational newest-first priority matcher over DEPTH entries.
  - Inputs: entry addr/valid vectors, head and tail pointers, in-flight-head mask.
  - Outputs: hit, index.
- write_buffer keeps the FIFO storage, pointers and both control engines.

Test Plan:
1. Reset, then 4 writes to 0x10..0x13 (data 0xA0..0xA3) with mready held 0 -> ready=0 after the 4th, empty=0. Set mready=1 with a 2-cycle memory model -> mwe pulses at 0x10,0x11,0x12,0x13 in order, then empty=1.
2. Write 0x20=0x1111, then 0x20=0x2222 while buffer blocked -> count stays 1. Drain yields a single mwe to 0x20 with mout=0x2222.
3. Write 0x30=0xBEEF, then re addr=0x30 with mready=0 -> dout=0xBEEF the next cycle, ready never drops, mre never asserted.
4. Read miss 0x40 while a drain is in flight -> mre is issued only after the drain completes. Memory returns 0x5555 -> dout=0x5555, ready high on the completion cycle. Pending writes resume after.
5. Head 0x50 in flight, then write 0x50=0x9 -> new entry pushed (count 2). Two mwe to 0x50 with the old data then 0x9.
6. Assert rst=0 mid-drain with 3 entries -> mwe=0, ready=0, empty=1 immediately. After release, ready=1 and no further mwe.

Source files
------------

// File: rtl/write_buffer_pkg.sv
// rtl/write_buffer_pkg.sv - shared state encoding for the posted-write buffer
package write_buffer_pkg;

    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        S_IDLE     = 2'd0,
        S_RD_ISSUE = 2'd1,
        S_RD_WAIT  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - newest-first address matcher over the write buffer entries
module wb_match
    import write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH_BITS = 2
) (
    input  logic [ADDR_WIDTH-1:0]                      addr_i,
    input  logic [(1<<DEPTH_BITS)-1:0][ADDR_WIDTH-1:0] entry_addr_i,
    input  logic [(1<<DEPTH_BITS)-1:0]                 valid_i,
    input  logic [DEPTH_BITS-1:0]                      head_i,
    input  logic [DEPTH_BITS-1:0]                      tail_i,
    input  logic [(1<<DEPTH_BITS)-1:0]                 mask_i,
    output logic                                       hit_o,
    output logic [DEPTH_BITS-1:0]                      index_o
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic                  done;
    logic [DEPTH_BITS-1:0] idx;

    // Walk from tail-1 back to head; the first hit is the newest copy of the address.
    always_comb begin
        hit_o   = 1'b0;
        index_o = '0;
        done    = 1'b0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_i - DEPTH_BITS'(k + 1);
            if (!done && valid_i[idx] && !mask_i[idx] && (entry_addr_i[idx] == addr_i)) begin
                hit_o   = 1'b1;
                index_o = idx;
                done    = 1'b1;
            end
            if (idx == head_i) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - posted, coalescing write buffer between cache and memory
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] maddr,
    output logic [WORD_WIDTH-1:0] mout,
    input  logic [WORD_WIDTH-1:0] min,
    output logic                  mre,
    output logic                  mwe,
    input  logic                  mready,
    output logic                  empty
);

    localparam int DEPTH   = 1 << DEPTH_BITS;
    localparam int COUNT_W = DEPTH_BITS + 1;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr_q;
    logic [DEPTH-1:0][WORD_WIDTH-1:0] ent_data_q;
    logic [DEPTH-1:0]                 ent_valid_q;
    logic [DEPTH_BITS-1:0]            head_q, tail_q;
    logic [COUNT_W-1:0]               count_q;
    logic                             drain_busy_q, init_q;
    logic [ADDR_WIDTH-1:0]            rd_addr_q, maddr_q, maddr_d;
    logic [WORD_WIDTH-1:0]            mout_q, mout_d, dout_q, dout_d;
    logic                             mre_q, mre_d, mwe_q, mwe_d;
    wb_state_e                        state_q, state_d;

    logic                  rd_acc, wr_acc, rd_hit, wr_hit, push;
    logic                  drain_start, drain_done, rd_issue, rd_done;
    logic [DEPTH_BITS-1:0] rd_idx, wr_idx;
    logic [DEPTH-1:0]      inflight_mask;

    // init_q holds ready low for the first cycle out of reset.
    assign ready       = init_q && (state_q == S_IDLE) && (count_q < COUNT_W'(DEPTH));
    assign rd_acc      = re && ready;
    assign wr_acc      = we && ready && !re;
    assign drain_start = (count_q != '0) && !drain_busy_q && mready && (state_q == S_IDLE);
    assign drain_done  = drain_busy_q && mready && !mwe_q;
    assign rd_issue    = (state_q == S_RD_ISSUE) && !drain_busy_q && mready;
    assign rd_done     = (state_q == S_RD_WAIT) && mready && !mre_q;
    assign push        = wr_acc && !wr_hit;

    // A head whose drain launches this very edge is already committed to memory.
    assign inflight_mask = (drain_busy_q || drain_start) ? (DEPTH'(1) << head_q) : '0;

    wb_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_rd_match (
        .addr_i       (addr),
        .entry_addr_i (ent_addr_q),
        .valid_i      (ent_valid_q),
        .head_i       (head_q),
        .tail_i       (tail_q),
        .mask_i       ('0),
        .hit_o        (rd_hit),
        .index_o      (rd_idx)
    );

    wb_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_wr_match (
        .addr_i       (addr),
        .entry_addr_i (ent_addr_q),
        .valid_i      (ent_valid_q),
        .head_i       (head_q),
        .tail_i       (tail_q),
        .mask_i       (inflight_mask),
        .hit_o        (wr_hit),
        .index_o      (wr_idx)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (wr_hit) begin
                ent_data_q[wr_idx] <= din;
            end else begin
                ent_addr_q[tail_q] <= addr;
                ent_data_q[tail_q] <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            drain_busy_q <= 1'b0;
        end else begin
            if (drain_start) begin
                drain_busy_q <= 1'b1;
            end else if (drain_done) begin
                drain_busy_q <= 1'b0;
            end
            if (drain_done) begin
                ent_valid_q[head_q] <= 1'b0;
                head_q              <= head_q + DEPTH_BITS'(1);
            end
            if (push) begin
                ent_valid_q[tail_q] <= 1'b1;
                tail_q              <= tail_q + DEPTH_BITS'(1);
            end
            case ({push, drain_done})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rd_acc && !rd_hit) state_d = S_RD_ISSUE;
            S_RD_ISSUE: if (rd_issue)          state_d = S_RD_WAIT;
            S_RD_WAIT:  if (rd_done)           state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mre_d   = rd_issue;
        mwe_d   = drain_start;
        maddr_d = maddr_q;
        mout_d  = mout_q;
        dout_d  = dout_q;
        if (rd_issue) begin
            maddr_d = rd_addr_q;
        end else if (drain_start) begin
            maddr_d = ent_addr_q[head_q];
            mout_d  = ent_data_q[head_q];
        end
        if (rd_acc && rd_hit) begin
            dout_d = ent_data_q[rd_idx];
        end else if (rd_done) begin
            dout_d = min;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q    <= 1'b0;
            rd_addr_q <= '0;
            mre_q     <= 1'b0;
            mwe_q     <= 1'b0;
            maddr_q   <= '0;
            mout_q    <= '0;
            dout_q    <= '0;
        end else begin
            init_q  <= 1'b1;
            mre_q   <= mre_d;
            mwe_q   <= mwe_d;
            maddr_q <= maddr_d;
            mout_q  <= mout_d;
            dout_q  <= dout_d;
            if (rd_acc && !rd_hit) begin
                rd_addr_q <= addr;
            end
        end
    end

    assign mre   = mre_q;
    assign mwe   = mwe_q;
    assign maddr = maddr_q;
    assign mout  = mout_q;
    assign dout  = dout_q;
    assign empty = (count_q == '0) && !drain_busy_q;

endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - scoreboard bench for the posted write buffer
module tb_write_buffer;

    typedef struct {
        bit          w;
        logic [63:0] a;
        logic [63:0] d;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] addr = '0, din = '0, min = '0;
    logic        re = 1'b0, we = 1'b0, mready = 1'b0;
    logic [63:0] dout, maddr, mout;
    logic        ready, mre, mwe, empty;

    int          n_cmp = 0, n_fail = 0;
    int          mem_cnt = 0, mwe_cnt = 0, mre_cnt = 0;
    int          rd_req = 0, rd_done = 0;
    bit          mem_en = 1'b0;
    op_t         op_q[$];
    logic [63:0] rd_exp_q[$];

    write_buffer #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .DEPTH_BITS(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
        .re(re), .we(we), .ready(ready), .maddr(maddr), .mout(mout),
        .min(min), .mre(mre), .mwe(mwe), .mready(mready), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: two busy cycles per op, min presented from issue until completion.
    always @(negedge clk) begin
        if (mwe || mre) begin
            chk("mem_op_while_busy", 64'(mem_cnt != 0 || !mready), 64'd0);
            if (mwe) mwe_cnt++;
            if (mre) begin
                mre_cnt++;
                min = (maddr == 64'h40) ? 64'h5555 : (maddr ^ 64'hDEAD_0000);
            end
            mready  = 1'b0;
            mem_cnt = 2;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) mready = mem_en;
        end else begin
            mready = mem_en;
        end
    end

    // Monitor: compares every memory pulse and every completed read against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (mwe || mre) begin
                if (op_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_mem_op: mwe=%0b mre=%0b maddr=0x%0h", mwe, mre, maddr);
                end else begin
                    op_t op;
                    op = op_q.pop_front();
                    chk("op_is_write", 64'(mwe), 64'(op.w));
                    chk("op_addr", maddr, op.a);
                    if (op.w) chk("op_wdata", mout, op.d);
                end
            end
            if (rd_done < rd_req && ready) begin
                chk("rd_data", dout, rd_exp_q.pop_front());
                rd_done++;
            end
        end
    end

    task automatic expect_op(input bit w, input logic [63:0] a, input logic [63:0] d);
        op_t op;
        op.w = w; op.a = a; op.d = d;
        op_q.push_back(op);
    endtask

    task automatic set_mem(input bit en);
        mem_en = en;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: ready timeout got %0b expected 1", tag, ready);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d);
        wait_ready("write_wait");
        we = 1'b1; addr = a; din = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [63:0] exp, input bit chk_ready);
        int n = 0;
        wait_ready("read_wait");
        rd_exp_q.push_back(exp);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        if (chk_ready) chk("rd_hit_ready_held", 64'(ready), 64'd1);
        rd_req++;
        while (rd_done != rd_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rd_done != rd_req) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_complete: got %0d reads expected %0d", rd_done, rd_req);
        end
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (empty !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(empty), 64'd1);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_mwe", 64'(mwe), 64'd0);
        chk("rst_mre", 64'(mre), 64'd0);
        chk("rst_maddr", maddr, 64'd0);
        chk("rst_mout", mout, 64'd0);
        chk("rst_dout", dout, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(ready), 64'd1);

        // 1: fill to full with memory stalled, then drain in order
        for (int i = 0; i < 4; i++) expect_op(1'b1, 64'h10 + 64'(i), 64'hA0 + 64'(i));
        for (int i = 0; i < 4; i++) do_write(64'h10 + 64'(i), 64'hA0 + 64'(i));
        chk("full_ready", 64'(ready), 64'd0);
        chk("full_empty", 64'(empty), 64'd0);
        chk("no_drain_while_stalled", 64'(mwe_cnt), 64'd0);
        set_mem(1'b1);
        wait_empty("t1_empty");
        chk("t1_mwe_count", 64'(mwe_cnt), 64'd4);

        // 2: coalesce two writes to the same address
        set_mem(1'b0);
        do_write(64'h20, 64'h1111);
        do_write(64'h20, 64'h2222);
        chk("coalesce_count", 64'(dut.count_q), 64'd1);
        expect_op(1'b1, 64'h20, 64'h2222);
        base = mwe_cnt;
        set_mem(1'b1);
        wait_empty("t2_empty");
        chk("coalesce_single_mwe", 64'(mwe_cnt - base), 64'd1);

        // 3: read forwarded from the buffer with memory stalled
        set_mem(1'b0);
        do_write(64'h30, 64'hBEEF);
        base = mre_cnt;
        do_read(64'h30, 64'hBEEF, 1'b1);
        chk("fwd_no_mre", 64'(mre_cnt - base), 64'd0);
        expect_op(1'b1, 64'h30, 64'hBEEF);
        set_mem(1'b1);
        wait_empty("t3_empty");

        // 4: read miss waits for the drain in flight; the second write drains afterwards
        expect_op(1'b1, 64'h60, 64'h6);
        expect_op(1'b0, 64'h40, 64'h0);
        expect_op(1'b1, 64'h61, 64'h7);
        do_write(64'h60, 64'h6);
        do_write(64'h61, 64'h7);
        do_read(64'h40, 64'h5555, 1'b0);
        chk("miss_ready_after", 64'(ready), 64'd1);
        wait_empty("t4_empty");

        // 5: rewrite of the in-flight head is pushed as a new entry
        expect_op(1'b1, 64'h50, 64'h1);
        expect_op(1'b1, 64'h50, 64'h9);
        do_write(64'h50, 64'h1);
        @(negedge clk);
        do_write(64'h50, 64'h9);
        chk("inflight_push_count", 64'(dut.count_q), 64'd2);
        wait_empty("t5_empty");

        // 6: reset mid-drain abandons the op and discards the remaining entries
        set_mem(1'b0);
        do_write(64'h70, 64'h70);
        do_write(64'h71, 64'h71);
        do_write(64'h72, 64'h72);
        expect_op(1'b1, 64'h70, 64'h70);
        mem_en = 1'b1;
        for (int n = 0; n < 50 && !mwe; n++) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_mwe", 64'(mwe), 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        base = mwe_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready), 64'd1);
        repeat (20) @(negedge clk);
        chk("post_rst_no_mwe", 64'(mwe_cnt - base), 64'd0);
        chk("ops_all_seen", 64'(op_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
